// File: rtl/ov5640_init_seq.sv
//==============================================================================
// Module   : ov5640_init_seq
// Brief    : OV5640 power-up sequencer and SCCB register-init ROM walker.
//            Drives PWDN/RESETB timing, then walks a command ROM of
//            {op, reg, val} words issuing SCCB writes and ms delays.
// Options  : define INIT_SEQ_RETRY_EN to re-issue a NACKed write up to
//            MAX_RETRY times before flagging an error.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ov5640_init_seq #(
  parameter int TICKS_PER_MS = 50000,
  parameter int ROM_AW       = 8,
  parameter int PWDN_MS      = 1,
  parameter int RST_MS       = 1,
  parameter int BOOT_MS      = 20,
  parameter int MAX_RETRY    = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic              sccb_req_o,
  output logic [15:0]       sccb_reg_o,
  output logic [7:0]        sccb_val_o,
  input  logic              sccb_done_i,
  input  logic              sccb_err_i,
  output logic              cam_pwdn_o,
  output logic              cam_rstn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ROM_AW-1:0] fail_addr_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PWDN   = 4'd1,
    S_RSTW   = 4'd2,
    S_BOOT   = 4'd3,
    S_FETCH  = 4'd4,
    S_DECODE = 4'd5,
    S_REQ    = 4'd6,
    S_WAIT   = 4'd7,
    S_DELAY  = 4'd8,
    S_DONE   = 4'd9,
    S_ERR    = 4'd10
  } state_t;

  localparam int                TW          = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0]     C_TICK_LAST = TW'(TICKS_PER_MS - 1);
  localparam logic [15:0]       C_PWDN_LAST = 16'(PWDN_MS - 1);
  localparam logic [15:0]       C_RST_LAST  = 16'(RST_MS - 1);
  localparam logic [15:0]       C_BOOT_LAST = 16'(BOOT_MS - 1);
  localparam logic [7:0]        C_OP_WRITE  = 8'h00;
  localparam logic [7:0]        C_OP_DELAY  = 8'h01;
  localparam logic [7:0]        C_OP_END    = 8'hFF;
  localparam logic [ROM_AW-1:0] C_ADDR_LAST = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            w_adv_state;
  logic [TW-1:0]     r_tick;
  logic [15:0]       r_ms;
  logic [15:0]       w_ms_target;
  logic              w_tick;
  logic              w_ms_expired;
  logic [15:0]       r_reg;
  logic [7:0]        r_val;
  logic [ROM_AW-1:0] r_addr;
  logic [ROM_AW-1:0] r_fail;
  logic              r_pwdn;
  logic              r_rstn;
  logic              w_retry_exhausted;

  wire logic [7:0]  w_op  = rom_data_i[31:24];
  wire logic [15:0] w_reg = rom_data_i[23:8];
  wire logic [7:0]  w_val = rom_data_i[7:0];

  assign w_tick      = (r_tick == C_TICK_LAST);
  // The last ROM slot finishes the sequence instead of wrapping to 0.
  assign w_adv_state = (r_addr == C_ADDR_LAST) ? S_DONE : S_FETCH;

  // Select the ms count that ends the current timed state.
  always_comb begin
    w_ms_target = 16'd0;
    case (r_state)
      S_PWDN:  w_ms_target = C_PWDN_LAST;
      S_RSTW:  w_ms_target = C_RST_LAST;
      S_BOOT:  w_ms_target = C_BOOT_LAST;
      S_DELAY: w_ms_target = {8'd0, r_val} - 16'd1;
      default: w_ms_target = 16'd0;
    endcase
  end

  assign w_ms_expired = w_tick && (r_ms == w_ms_target);

`ifdef INIT_SEQ_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RW-1:0] r_retry;

  assign w_retry_exhausted = (r_retry == RW'(MAX_RETRY));

  // Count consecutive NACKs of the current entry; any ack or restart clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_retry <= '0;
    end else if ((r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR) && start_i) begin
      r_retry <= '0;
    end else if ((r_state == S_REQ || r_state == S_WAIT) && sccb_done_i) begin
      r_retry <= (sccb_err_i && !w_retry_exhausted) ? r_retry + 1'b1 : '0;
    end
  end
`else
  // Without retry support every NACK is fatal.
  assign w_retry_exhausted = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; a retried NACK refetches the same entry so the request drops for a cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start_i) w_state_nxt = S_PWDN;
      S_PWDN:  if (w_ms_expired) w_state_nxt = S_RSTW;
      S_RSTW:  if (w_ms_expired) w_state_nxt = S_BOOT;
      S_BOOT:  if (w_ms_expired) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (w_op)
          C_OP_WRITE: w_state_nxt = S_REQ;
          C_OP_DELAY: w_state_nxt = (w_val == 8'd0) ? w_adv_state : S_DELAY;
          C_OP_END:   w_state_nxt = S_DONE;
          default:    w_state_nxt = S_ERR;
        endcase
      end
      S_REQ, S_WAIT: begin
        if (sccb_done_i) begin
          if (!sccb_err_i)            w_state_nxt = w_adv_state;
          else if (w_retry_exhausted) w_state_nxt = S_ERR;
          else                        w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DELAY: if (w_ms_expired) w_state_nxt = w_adv_state;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Delay counters, ROM pointer, latched command and camera pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tick <= '0;
      r_ms   <= '0;
      r_reg  <= '0;
      r_val  <= '0;
      r_addr <= '0;
      r_fail <= '0;
      r_pwdn <= 1'b1;
      r_rstn <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) begin
        r_tick <= '0;
        r_ms   <= '0;
      end else if (w_tick) begin
        r_tick <= '0;
        r_ms   <= r_ms + 16'd1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            r_addr <= '0;
            r_pwdn <= 1'b1;
            r_rstn <= 1'b0;
          end
        end
        S_PWDN: if (w_ms_expired) r_pwdn <= 1'b0;
        S_RSTW: if (w_ms_expired) r_rstn <= 1'b1;
        S_DECODE: begin
          r_reg <= w_reg;
          r_val <= w_val;
          if (w_state_nxt == S_ERR)   r_fail <= r_addr;
          if (w_state_nxt == S_FETCH) r_addr <= r_addr + 1'b1;
        end
        S_REQ, S_WAIT: begin
          if (sccb_done_i) begin
            if (sccb_err_i) begin
              if (w_state_nxt == S_ERR) r_fail <= r_addr;
            end else if (w_state_nxt == S_FETCH) begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        S_DELAY: if (w_state_nxt == S_FETCH) r_addr <= r_addr + 1'b1;
        default: ;
      endcase
    end
  end

  assign rom_addr_o  = r_addr;
  assign fail_addr_o = r_fail;
  assign sccb_reg_o  = r_reg;
  assign sccb_val_o  = r_val;
  assign sccb_req_o  = (r_state == S_REQ) || (r_state == S_WAIT);
  assign cam_pwdn_o  = r_pwdn;
  assign cam_rstn_o  = r_rstn;
  assign busy_o      = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign done_o      = (r_state == S_DONE);
  assign error_o     = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_ov5640_init_seq.sv
//==============================================================================
// Module   : tb_ov5640_init_seq
// Brief    : Directed self-checking bench for ov5640_init_seq with a
//            behavioural command ROM and SCCB responder (TICKS_PER_MS=10).
// Options  : follows INIT_SEQ_RETRY_EN to pick the NACK scenario.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ov5640_init_seq;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic          sccb_req;
  logic [15:0]   sccb_reg;
  logic [7:0]    sccb_val;
  logic          sccb_done = 1'b0;
  logic          sccb_err = 1'b0;
  logic          cam_pwdn, cam_rstn, busy, done, error;
  logic [AW-1:0] fail_addr;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom [16];
  assign rom_data = rom[rom_addr];

  ov5640_init_seq #(
    .TICKS_PER_MS(10), .ROM_AW(AW), .PWDN_MS(1), .RST_MS(1), .BOOT_MS(20), .MAX_RETRY(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .sccb_req_o(sccb_req), .sccb_reg_o(sccb_reg), .sccb_val_o(sccb_val),
    .sccb_done_i(sccb_done), .sccb_err_i(sccb_err),
    .cam_pwdn_o(cam_pwdn), .cam_rstn_o(cam_rstn),
    .busy_o(busy), .done_o(done), .error_o(error), .fail_addr_o(fail_addr)
  );

  always #5 clk = ~clk;

  // SCCB responder: acks 3 cycles after a request rises, NACKs entry nack_addr nack_left times.
  bit          auto_ack = 1'b1;
  int          nack_left = 0;
  int          nack_addr = -1;
  int          req_count = 0;
  int          lat = 0;
  bit          unstable = 1'b0;
  logic        req_q = 1'b0;
  logic [15:0] seen_reg = '0;
  logic [7:0]  seen_val = '0;

  always @(negedge clk) begin
    sccb_done = 1'b0;
    sccb_err  = 1'b0;
    if (sccb_req && !req_q) begin
      req_count++;
      seen_reg = sccb_reg;
      seen_val = sccb_val;
      lat = 0;
    end
    if (sccb_req) begin
      if (sccb_reg !== seen_reg || sccb_val !== seen_val) unstable = 1'b1;
      if (auto_ack) begin
        lat++;
        if (lat == 3) begin
          sccb_done = 1'b1;
          if (nack_left > 0 && int'(rom_addr) == nack_addr) begin
            sccb_err = 1'b1;
            nack_left--;
          end
        end
      end
    end
    req_q = sccb_req;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_rom(input logic [31:0] word);
    for (int i = 0; i < 16; i++) rom[i] = word;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    step(3);
    checks++;
    if ({sccb_req, busy, done, error, cam_pwdn, cam_rstn} !== 6'b000010) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000010 (req,busy,done,err,pwdn,rstn)",
               {sccb_req, busy, done, error, cam_pwdn, cam_rstn});
    end
    checks++;
    if (rom_addr !== 4'd0 || fail_addr !== 4'd0) begin
      failures++;
      $display("FAIL reset_addr: got rom_addr=%0d fail_addr=%0d expected 0/0", rom_addr, fail_addr);
    end
    rst = 1'b0;
    step(5);
    checks++;
    if (busy !== 1'b0 || cam_pwdn !== 1'b1) begin
      failures++;
      $display("FAIL idle_hold: got busy=%b pwdn=%b expected 0/1", busy, cam_pwdn);
    end
  endtask

  // Power-up timing: pwdn falls after 10 cycles, rstn 10 later, first request 200+2 later.
  task automatic test_power_seq();
    int n;
    fill_rom(32'hFF00_0000);
    rom[0] = 32'h0030_0812;
    rom[1] = 32'h0100_0005;
    req_count = 0;
    unstable = 1'b0;
    pulse_start();
    checks++;
    if ({busy, done, error, cam_pwdn, cam_rstn} !== 5'b10010) begin
      failures++;
      $display("FAIL start_flags: got %b expected 10010 (busy,done,err,pwdn,rstn)",
               {busy, done, error, cam_pwdn, cam_rstn});
    end
    n = 0;
    while (cam_pwdn && n < 100) begin step(1); n++; end
    checks++;
    if (n !== 10) begin failures++; $display("FAIL pwdn_fall: got %0d cycles expected 10", n); end
    n = 0;
    while (!cam_rstn && n < 100) begin step(1); n++; end
    checks++;
    if (n !== 10) begin failures++; $display("FAIL rstn_rise: got %0d cycles expected 10", n); end
    n = 0;
    while (!sccb_req && n < 1000) begin step(1); n++; end
    checks++;
    if (n !== 202) begin failures++; $display("FAIL first_req: got %0d cycles expected 202", n); end
  endtask

  // Continues the previous run: write 0x3008=0x12, 5 ms delay (50 cycles + 4 of fetch/decode), end.
  task automatic test_write_delay();
    int n;
    n = 0;
    while (sccb_req && n < 50) begin step(1); n++; end
    checks++;
    if ({seen_reg, seen_val} !== 24'h3008_12) begin
      failures++;
      $display("FAIL write_data: got %h expected 300812", {seen_reg, seen_val});
    end
    n = 0;
    while (!done && n < 300) begin step(1); n++; end
    checks++;
    if (n !== 54) begin failures++; $display("FAIL delay_gap: got %0d cycles expected 54", n); end
    checks++;
    if (rom_addr !== 4'd2 || req_count !== 1 || unstable !== 1'b0) begin
      failures++;
      $display("FAIL done_state: got addr=%0d reqs=%0d unstable=%b expected 2/1/0",
               rom_addr, req_count, unstable);
    end
    checks++;
    if ({busy, error, cam_pwdn, cam_rstn} !== 4'b0001) begin
      failures++;
      $display("FAIL done_pins: got %b expected 0001 (busy,err,pwdn,rstn)", {busy, error, cam_pwdn, cam_rstn});
    end
  endtask

  // Bad opcode at entry 1, stray start while busy, restart from ERR.
  task automatic test_bad_op();
    int n;
    fill_rom(32'hFF00_0000);
    rom[0] = 32'h0043_0030;
    rom[1] = 32'h7E00_0000;
    req_count = 0;
    pulse_start();
    step(4);
    pulse_start();
    n = 0;
    while (cam_pwdn && n < 100) begin step(1); n++; end
    checks++;
    if (n !== 5) begin failures++; $display("FAIL busy_start: got pwdn fall after %0d cycles expected 5", n); end
    n = 0;
    while (!error && n < 1000) begin step(1); n++; end
    checks++;
    if ({error, busy, cam_pwdn, cam_rstn} !== 4'b1001 || fail_addr !== 4'd1 || req_count !== 1) begin
      failures++;
      $display("FAIL bad_op: got flags=%b fail=%0d reqs=%0d expected 1001/1/1",
               {error, busy, cam_pwdn, cam_rstn}, fail_addr, req_count);
    end
    pulse_start();
    checks++;
    if ({busy, error, done, cam_pwdn, cam_rstn} !== 5'b10010 || rom_addr !== 4'd0) begin
      failures++;
      $display("FAIL err_restart: got flags=%b addr=%0d expected 10010/0",
               {busy, error, done, cam_pwdn, cam_rstn}, rom_addr);
    end
    n = 0;
    while (!error && n < 1000) begin step(1); n++; end
    checks++;
    if (error !== 1'b1 || fail_addr !== 4'd1) begin
      failures++;
      $display("FAIL bad_op_again: got err=%b fail=%0d expected 1/1", error, fail_addr);
    end
  endtask

`ifdef INIT_SEQ_RETRY_EN
  // Entry 0 NACKed 3 times then acked -> 4 requests and done; NACKed 4 times -> error.
  task automatic test_nack();
    int n;
    fill_rom(32'hFF00_0000);
    rom[0] = 32'h0031_0311;
    nack_addr = 0;
    nack_left = 3;
    req_count = 0;
    pulse_start();
    n = 0;
    while (!done && !error && n < 2000) begin step(1); n++; end
    checks++;
    if ({done, error} !== 2'b10 || req_count !== 4) begin
      failures++;
      $display("FAIL retry_ok: got done,err=%b reqs=%0d expected 10/4", {done, error}, req_count);
    end
    nack_left = 4;
    req_count = 0;
    pulse_start();
    n = 0;
    while (!done && !error && n < 2000) begin step(1); n++; end
    checks++;
    if ({done, error} !== 2'b01 || fail_addr !== 4'd0 || req_count !== 4) begin
      failures++;
      $display("FAIL retry_exhaust: got done,err=%b fail=%0d reqs=%0d expected 01/0/4",
               {done, error}, fail_addr, req_count);
    end
    nack_addr = -1;
    nack_left = 0;
  endtask
`else
  // Single NACK at entry 3 is fatal; no further requests follow.
  task automatic test_nack();
    int n;
    fill_rom(32'hFF00_0000);
    rom[0] = 32'h0030_0001;
    rom[1] = 32'h0030_0102;
    rom[2] = 32'h0030_0203;
    rom[3] = 32'h0030_0304;
    nack_addr = 3;
    nack_left = 1;
    req_count = 0;
    pulse_start();
    n = 0;
    while (!done && !error && n < 2000) begin step(1); n++; end
    checks++;
    if ({done, error} !== 2'b01 || fail_addr !== 4'd3 || req_count !== 4) begin
      failures++;
      $display("FAIL nack_err: got done,err=%b fail=%0d reqs=%0d expected 01/3/4",
               {done, error}, fail_addr, req_count);
    end
    step(40);
    checks++;
    if (req_count !== 4 || sccb_req !== 1'b0 || error !== 1'b1) begin
      failures++;
      $display("FAIL nack_quiet: got reqs=%0d req=%b err=%b expected 4/0/1", req_count, sccb_req, error);
    end
    nack_addr = -1;
    nack_left = 0;
  endtask
`endif

  // Every entry a zero-length delay: the pointer stops at 15 and the run ends there.
  task automatic test_last_addr();
    int n;
    fill_rom(32'h0100_0000);
    pulse_start();
    n = 0;
    while (!done && !error && n < 1000) begin step(1); n++; end
    checks++;
    if ({done, error} !== 2'b10 || rom_addr !== 4'd15) begin
      failures++;
      $display("FAIL last_addr: got done,err=%b addr=%0d expected 10/15", {done, error}, rom_addr);
    end
  endtask

  // Reset during WAIT drops the request next cycle and restores reset values.
  task automatic test_reset_mid();
    int n;
    fill_rom(32'hFF00_0000);
    rom[0] = 32'h0030_0812;
    auto_ack = 1'b0;
    pulse_start();
    n = 0;
    while (!sccb_req && n < 1000) begin step(1); n++; end
    step(2);
    checks++;
    if (sccb_req !== 1'b1) begin failures++; $display("FAIL wait_hold: got req=%b expected 1", sccb_req); end
    rst = 1'b1;
    step(1);
    checks++;
    if ({sccb_req, busy, done, error, cam_pwdn, cam_rstn} !== 6'b000010) begin
      failures++;
      $display("FAIL mid_reset_flags: got %b expected 000010", {sccb_req, busy, done, error, cam_pwdn, cam_rstn});
    end
    checks++;
    if (rom_addr !== 4'd0 || fail_addr !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset_addr: got rom_addr=%0d fail_addr=%0d expected 0/0", rom_addr, fail_addr);
    end
    rst = 1'b0;
    auto_ack = 1'b1;
    step(20);
    checks++;
    if (busy !== 1'b0 || sccb_req !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got busy=%b req=%b expected 0/0", busy, sccb_req);
    end
  endtask

  initial begin
    fill_rom(32'hFF00_0000);
    test_reset();
    test_power_seq();
    test_write_delay();
    test_bad_op();
    test_nack();
    test_last_addr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
